// File: rtl/fp_stream_accumulator.sv
// fp_stream_accumulator: valid/ready running-sum reduction of single-precision operands over one fp_adder
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  logic        swap, nan;
  logic [31:0] x, z;
  logic [9:0]  ex, ez, d, e;
  logic [4:0]  dc, lz, sh;
  logic [26:0] mx, my, n;
  logic [53:0] al;
  logic [27:0] s;
  logic [24:0] r;
  logic        up;
  always_comb begin
    swap = b[30:0] > a[30:0];
    x = swap ? b : a;
    z = swap ? a : b;
    nan = (&a[30:23] & |a[22:0]) | (&b[30:23] & |b[22:0]) |
          (&a[30:23] & &b[30:23] & (a[31] ^ b[31]));
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b0, x[30:23]};
    ez = (z[30:23] == 8'd0) ? 10'd1 : {2'b0, z[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b0};
    d = ex - ez;
    dc = (d > 10'd31) ? 5'd31 : d[4:0];
    al = {z[30:23] != 8'd0, z[22:0], 3'b0, 27'b0} >> dc;
    my = al[53:27] | {26'b0, |al[26:0]};
    s = (x[31] == z[31]) ? {1'b0, mx} + {1'b0, my} : {1'b0, mx} - {1'b0, my};
    lz = 5'd27;
    for (int i = 0; i < 27; i++) if (s[i]) lz = 5'(26 - i);
    sh = ({5'd0, lz} > ex - 10'd1) ? 5'(ex - 10'd1) : lz;
    n = s[27] ? (s[27:1] | {26'b0, s[0]}) : (s[26:0] << sh);
    e = s[27] ? ex + 10'd1 : ex - {5'd0, sh};
    up = n[2] & (n[3] | n[1] | n[0]);
    r = {1'b0, n[26:3]} + {24'b0, up};
    e = r[24] ? e + 10'd1 : e;
    r = r[24] ? r >> 1 : r;
    y = {x[31], r[23] ? e[7:0] : 8'd0, r[22:0]};
    if (e >= 10'd255) y = {x[31], 8'hFF, 23'b0};
    if (s == 28'd0) y = {x[31] & z[31], 31'b0};
    if (&x[30:23]) y = x;
    if (nan) y = 32'h7FC00000;
  end
endmodule

module fp_stream_accumulator #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t           state, state_n;
  logic [31:0]      acc, sum;
  logic [LEN_W-1:0] count, remaining;
  logic             fire;
  fp_adder adder (.a(acc), .b(in_data ^ {in_sub, 31'b0}), .y(sum));
  assign fire      = in_valid && state == ACC;
  assign in_ready  = state == ACC;
  assign out_valid = state == HOLD;
  assign busy      = state != IDLE;
  assign out_sum   = acc;
  assign out_count = count;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? (len != '0 ? ACC : HOLD) : IDLE;
      ACC:     state_n = (fire && remaining == LEN_W'(1)) ? HOLD : ACC;
      HOLD:    state_n = out_ready ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      remaining <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        acc       <= '0;
        count     <= '0;
        remaining <= len;
      end else if (fire) begin
        acc       <= sum;
        count     <= count + LEN_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_fp_stream_accumulator.sv
// tb_fp_stream_accumulator: directed checks of fp_stream_accumulator job flow, arithmetic and handshakes
module tb_fp_stream_accumulator;
  logic        clk = 1'b0;
  logic        rst_n, start, in_valid, in_sub, out_ready;
  logic [7:0]  len;
  logic [31:0] in_data;
  logic        in_ready, out_valid, busy;
  logic [31:0] out_sum;
  logic [7:0]  out_count;
  int          n_checks = 0;
  int          n_fails = 0;

  fp_stream_accumulator #(.LEN_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic begin_job(input logic [7:0] l);
    start = 1'b1;
    len = l;
    @(negedge clk);
    start = 1'b0;
    len = 8'hAA;
  endtask

  task automatic push(input logic [31:0] v, input logic sub);
    in_valid = 1'b1;
    in_data = v;
    in_sub = sub;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = 32'hDEADBEEF;
    in_sub = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(out_valid), 32'd1);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
    in_data = 32'd0; in_sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sum", out_sum, 32'h0);
    chk("rst_out_count", 32'(out_count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    begin_job(8'd3);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_in_ready", 32'(in_ready), 32'd1);
    push(32'h3F800000, 1'b0);
    push(32'h40000000, 1'b0);
    chk("basic_not_done", 32'(out_valid), 32'd0);
    push(32'h40400000, 1'b0);
    chk("basic_out_valid", 32'(out_valid), 32'd1);
    chk("basic_sum", out_sum, 32'h40C00000);
    chk("basic_count", 32'(out_count), 32'd3);
    chk("basic_in_ready_hold", 32'(in_ready), 32'd0);
    ack();
    chk("basic_idle", 32'(busy), 32'd0);

    begin_job(8'd2);
    push(32'h40400000, 1'b0);
    push(32'h40000000, 1'b1);
    chk("sub_out_valid", 32'(out_valid), 32'd1);
    chk("sub_sum", out_sum, 32'h3F800000);
    chk("sub_count", 32'(out_count), 32'd2);
    ack();

    begin_job(8'd2);
    push(32'h3F800000, 1'b0);
    push(32'h3F800000, 1'b1);
    chk("cancel_sum", out_sum, 32'h00000000);
    ack();

    begin_job(8'd3);
    push(32'h3F800000, 1'b0);
    repeat (2) @(negedge clk);
    chk("stall_count_mid", 32'(out_count), 32'd1);
    push(32'h3F800000, 1'b0);
    repeat (2) @(negedge clk);
    push(32'h3F800000, 1'b0);
    wait_out("stall_out_valid");
    chk("stall_sum", out_sum, 32'h40400000);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      len = 8'd5;
      @(negedge clk);
      chk("bp_sum_stable", out_sum, 32'h40400000);
      chk("bp_count_stable", 32'(out_count), 32'd3);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
    end
    start = 1'b0;
    ack();
    chk("bp_released", 32'(busy), 32'd0);

    begin_job(8'd0);
    chk("zero_out_valid", 32'(out_valid), 32'd1);
    chk("zero_sum", out_sum, 32'h0);
    chk("zero_count", 32'(out_count), 32'd0);
    chk("zero_in_ready", 32'(in_ready), 32'd0);
    ack();
    chk("zero_idle", 32'(busy), 32'd0);

    begin_job(8'd4);
    push(32'h40000000, 1'b0);
    push(32'h40000000, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_out_valid", 32'(out_valid), 32'd0);
    chk("mrst_sum", out_sum, 32'h0);
    chk("mrst_count", 32'(out_count), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    begin_job(8'd1);
    push(32'h3F000000, 1'b0);
    chk("mrst_new_valid", 32'(out_valid), 32'd1);
    chk("mrst_new_sum", out_sum, 32'h3F000000);
    chk("mrst_new_count", 32'(out_count), 32'd1);

    start = 1'b1;
    len = 8'd2;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    out_ready = 1'b0;
    chk("hs_start_busy", 32'(busy), 32'd0);
    chk("hs_start_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("hs_start_still_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
